// File: rtl/menu_pkg.sv
// Shared encodings, field limits and helpers for the settings menu.
package menu_pkg;

    typedef enum logic [3:0] {
        ST_TEMP   = 4'd0,
        ST_HUM    = 4'd1,
        ST_TIME_H = 4'd2,
        ST_TIME_M = 4'd3,
        ST_SUN_H  = 4'd4,
        ST_SUN_M  = 4'd5
    } menu_state_e;

    localparam menu_state_e ST_LAST = ST_SUN_M;

    localparam logic [7:0] HUM_MAX  = 8'd99;
    localparam logic [4:0] HOUR_MAX = 5'd23;
    localparam logic [5:0] MIN_MAX  = 6'd59;

    // Width of a counter able to hold the larger of the two repeat intervals.
    function automatic int rpt_cnt_width(input int delay, input int rate);
        int m;
        m = (delay > rate) ? delay : rate;
        return $clog2(m + 1);
    endfunction

    // Hour field step with 23<->0 wrap.
    function automatic logic [4:0] wrap_hour(input logic [4:0] v, input logic up);
        if (up) return (v >= HOUR_MAX) ? 5'd0 : v + 5'd1;
        else    return (v == 5'd0) ? HOUR_MAX : v - 5'd1;
    endfunction

    // Minute field step with 59<->0 wrap.
    function automatic logic [5:0] wrap_min(input logic [5:0] v, input logic up);
        if (up) return (v >= MIN_MAX) ? 6'd0 : v + 6'd1;
        else    return (v == 6'd0) ? MIN_MAX : v - 6'd1;
    endfunction

endpackage

// File: rtl/menu_controller_button_pulse.sv
// Raw push-button to step pulse: 2-flop synchronizer, rising-edge detect,
// optional hold-to-repeat. The synchronizer resets to "pressed" so a button
// held through reset has to be released before it can produce a pulse.
// clr cancels the current hold: counters clear and the button stays blocked
// until it is released. pulse is combinational from local flops so the
// consumer's register update lands on the 3rd clock edge after the press.
module button_pulse
    import menu_pkg::*;
#(
    parameter bit REPEAT_EN    = 1'b0,
    parameter int REPEAT_DELAY = 12500000,
    parameter int REPEAT_RATE  = 2500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    input  logic clr,
    output logic pulse,
    output logic held
);

    localparam int CW = rpt_cnt_width(REPEAT_DELAY, REPEAT_RATE);

    logic r_s1, r_s2, r_s3;
    logic r_blk;
    logic w_edge;

    // Synchronizer plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= btn;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Block flag: set by clr while held (or by reset), released when the button is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blk <= 1'b1;
        end else if (!r_s2) begin
            r_blk <= 1'b0;
        end else if (clr) begin
            r_blk <= 1'b1;
        end
    end

    assign w_edge = r_s2 & ~r_s3 & ~r_blk;
    assign held   = r_s2;

    if (REPEAT_EN) begin : g_rpt
        logic [CW-1:0] r_cnt;
        logic          r_rep;
        logic          w_fire;

        // r_cnt counts cycles since the press (first phase) or since the last repeat.
        assign w_fire = r_s2 & ~r_blk &
                        (r_rep ? (r_cnt == CW'(REPEAT_RATE)) : (r_cnt == CW'(REPEAT_DELAY)));

        // Hold-time counter for auto-repeat.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
                r_rep <= 1'b0;
            end else if (!r_s2 || r_blk || clr) begin
                r_cnt <= '0;
                r_rep <= 1'b0;
            end else if (w_fire) begin
                r_cnt <= CW'(1);
                r_rep <= 1'b1;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end

        assign pulse = w_edge | w_fire;
    end else begin : g_norpt
        assign pulse = w_edge;
    end

endmodule

// File: rtl/menu_controller.sv
// Settings menu sequencer: cursor over six fields, button-driven edits of
// setpoints, and a running time of day advanced by minute_tick.
module menu_controller
    import menu_pkg::*;
#(
    parameter int REPEAT_DELAY      = 12500000,
    parameter int REPEAT_RATE       = 2500000,
    parameter int TEMP_MIN          = 40,
    parameter int TEMP_MAX          = 120,
    parameter int TEMP_DEFAULT      = 75,
    parameter int HUM_DEFAULT       = 50,
    parameter int SUNRISE_H_DEFAULT = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_next,
    input  logic        btn_prev,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        minute_tick,
    output logic [3:0]  state,
    output logic [11:0] set_temp,
    output logic [7:0]  set_hum,
    output logic [4:0]  time_hours,
    output logic [5:0]  time_minutes,
    output logic [4:0]  sunrise_hours,
    output logic [5:0]  sunrise_minutes
);

    localparam logic [11:0] L_TEMP_MIN = 12'(TEMP_MIN);
    localparam logic [11:0] L_TEMP_MAX = 12'(TEMP_MAX);

    logic w_next_p, w_prev_p, w_up_p, w_dn_p;
    logic w_next_held, w_prev_held, w_up_held, w_dn_held;
    logic w_next_mv, w_prev_mv, w_cursor_mv;
    logic w_both, w_clr_rpt;
    logic w_step_up, w_step_dn, w_step_any, w_tick_ok;

    menu_state_e r_state, w_state_next;
    logic [11:0] r_temp, w_temp_n;
    logic [7:0]  r_hum, w_hum_n;
    logic [4:0]  r_th, w_th_n, r_sh, w_sh_n;
    logic [5:0]  r_tm, w_tm_n, r_sm, w_sm_n;

    button_pulse #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_next (
        .clk(clk), .rst_n(rst_n), .btn(btn_next), .clr(1'b0), .pulse(w_next_p), .held(w_next_held));
    button_pulse #(.REPEAT_EN(1'b0), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_prev (
        .clk(clk), .rst_n(rst_n), .btn(btn_prev), .clr(1'b0), .pulse(w_prev_p), .held(w_prev_held));
    button_pulse #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_up (
        .clk(clk), .rst_n(rst_n), .btn(btn_up), .clr(w_clr_rpt), .pulse(w_up_p), .held(w_up_held));
    button_pulse #(.REPEAT_EN(1'b1), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_down (
        .clk(clk), .rst_n(rst_n), .btn(btn_down), .clr(w_clr_rpt), .pulse(w_dn_p), .held(w_dn_held));

    // Opposing buttons held together cancel each other.
    assign w_next_mv   = w_next_p & ~w_prev_held;
    assign w_prev_mv   = w_prev_p & ~w_next_held;
    assign w_cursor_mv = w_next_mv | w_prev_mv;
    assign w_both      = w_up_held & w_dn_held;
    assign w_clr_rpt   = w_cursor_mv | w_both;
    assign w_step_up   = w_up_p & ~w_both;
    assign w_step_dn   = w_dn_p & ~w_both;
    assign w_step_any  = w_step_up | w_step_dn;
    // An edit of the clock fields overrides a simultaneous minute tick.
    assign w_tick_ok   = minute_tick &
                         ~(w_step_any & ((r_state == ST_TIME_H) | (r_state == ST_TIME_M)));

    // Cursor state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_TEMP;
        else        r_state <= w_state_next;
    end

    // Cursor next state: wrap in both directions.
    always_comb begin
        w_state_next = r_state;
        if (w_next_mv) begin
            w_state_next = (r_state == ST_LAST) ? ST_TEMP : menu_state_e'(r_state + 4'd1);
        end else if (w_prev_mv) begin
            w_state_next = (r_state == ST_TEMP) ? ST_LAST : menu_state_e'(r_state - 4'd1);
        end
    end

    // Field next values: minute tick first, then the step on the old cursor field.
    always_comb begin
        w_temp_n = r_temp;
        w_hum_n  = r_hum;
        w_th_n   = r_th;
        w_tm_n   = r_tm;
        w_sh_n   = r_sh;
        w_sm_n   = r_sm;
        if (w_tick_ok) begin
            w_tm_n = wrap_min(r_tm, 1'b1);
            if (r_tm >= MIN_MAX) w_th_n = wrap_hour(r_th, 1'b1);
        end
        if (w_step_any) begin
            case (r_state)
                ST_TEMP: begin
                    if (w_step_up) w_temp_n = (r_temp >= L_TEMP_MAX) ? L_TEMP_MAX : r_temp + 12'd1;
                    else           w_temp_n = (r_temp <= L_TEMP_MIN) ? L_TEMP_MIN : r_temp - 12'd1;
                end
                ST_HUM: begin
                    if (w_step_up) w_hum_n = (r_hum >= HUM_MAX) ? HUM_MAX : r_hum + 8'd1;
                    else           w_hum_n = (r_hum == 8'd0) ? 8'd0 : r_hum - 8'd1;
                end
                ST_TIME_H: w_th_n = wrap_hour(r_th, w_step_up);
                ST_TIME_M: w_tm_n = wrap_min(r_tm, w_step_up);
                ST_SUN_H:  w_sh_n = wrap_hour(r_sh, w_step_up);
                ST_SUN_M:  w_sm_n = wrap_min(r_sm, w_step_up);
                default:   w_temp_n = r_temp;
            endcase
        end
    end

    // Field registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_temp <= 12'(TEMP_DEFAULT);
            r_hum  <= 8'(HUM_DEFAULT);
            r_th   <= 5'd0;
            r_tm   <= 6'd0;
            r_sh   <= 5'(SUNRISE_H_DEFAULT);
            r_sm   <= 6'd0;
        end else begin
            r_temp <= w_temp_n;
            r_hum  <= w_hum_n;
            r_th   <= w_th_n;
            r_tm   <= w_tm_n;
            r_sh   <= w_sh_n;
            r_sm   <= w_sm_n;
        end
    end

    assign state           = r_state;
    assign set_temp        = r_temp;
    assign set_hum         = r_hum;
    assign time_hours      = r_th;
    assign time_minutes    = r_tm;
    assign sunrise_hours   = r_sh;
    assign sunrise_minutes = r_sm;

endmodule

// File: tb/tb_menu_controller.sv
// Bench for menu_controller: directed scenarios with literal expectations,
// then randomized buttons/ticks, all compared every cycle against a
// behavioural model of the menu rules.
module tb_menu_controller;

    localparam int RD = 10;
    localparam int RR = 4;
    localparam int B_NEXT = 0, B_PREV = 1, B_UP = 2, B_DN = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  btn = 4'b0000;
    logic        minute_tick = 1'b0;
    logic [3:0]  state;
    logic [11:0] set_temp;
    logic [7:0]  set_hum;
    logic [4:0]  time_hours;
    logic [5:0]  time_minutes;
    logic [4:0]  sunrise_hours;
    logic [5:0]  sunrise_minutes;

    menu_controller #(.REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_next(btn[B_NEXT]), .btn_prev(btn[B_PREV]),
        .btn_up(btn[B_UP]), .btn_down(btn[B_DN]),
        .minute_tick(minute_tick),
        .state(state), .set_temp(set_temp), .set_hum(set_hum),
        .time_hours(time_hours), .time_minutes(time_minutes),
        .sunrise_hours(sunrise_hours), .sunrise_minutes(sunrise_minutes));

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- behavioural model ----------------
    // Raw button history: h[b][0] = raw at previous edge, [1] two edges ago, [2] three.
    bit [2:0] h [4];
    bit       blk [4];
    int       hold_len [4];
    int       m_state, m_temp, m_hum, m_mod, m_sun_h, m_sun_m;

    function automatic void model_reset();
        for (int b = 0; b < 4; b++) begin
            h[b] = 3'b111;
            blk[b] = 1'b1;
            hold_len[b] = 0;
        end
        m_state = 0; m_temp = 75; m_hum = 50; m_mod = 0; m_sun_h = 6; m_sun_m = 0;
    endfunction

    function automatic void model_step(input logic [3:0] raw, input logic tick_in);
        bit lvl [4];
        bit press [4];
        bit rp [4];
        bit nx, pv, up, dn, both, clr, tick;
        int d, hh, mm;
        for (int b = 0; b < 4; b++) begin
            lvl[b]   = h[b][1];
            press[b] = h[b][1] && !h[b][2] && !blk[b];
        end
        for (int b = 2; b < 4; b++)
            rp[b] = press[b] || (lvl[b] && !blk[b] && hold_len[b] >= RD && ((hold_len[b] - RD) % RR) == 0);
        nx   = press[B_NEXT] && !lvl[B_PREV];
        pv   = press[B_PREV] && !lvl[B_NEXT];
        both = lvl[B_UP] && lvl[B_DN];
        up   = rp[B_UP] && !both;
        dn   = rp[B_DN] && !both;
        tick = tick_in && !((up || dn) && (m_state == 2 || m_state == 3));
        if (tick) m_mod = (m_mod + 1) % 1440;
        if (up || dn) begin
            d  = up ? 1 : -1;
            hh = m_mod / 60;
            mm = m_mod % 60;
            case (m_state)
                0: m_temp = (m_temp + d > 120) ? 120 : (m_temp + d < 40) ? 40 : m_temp + d;
                1: m_hum  = (m_hum + d > 99) ? 99 : (m_hum + d < 0) ? 0 : m_hum + d;
                2: m_mod  = ((hh + d + 24) % 24) * 60 + mm;
                3: m_mod  = hh * 60 + (mm + d + 60) % 60;
                4: m_sun_h = (m_sun_h + d + 24) % 24;
                default: m_sun_m = (m_sun_m + d + 60) % 60;
            endcase
        end
        if (nx) m_state = (m_state + 1) % 6;
        if (pv) m_state = (m_state + 5) % 6;
        clr = nx || pv || both;
        for (int b = 0; b < 4; b++) begin
            hold_len[b] = (lvl[b] && !blk[b]) ? hold_len[b] + 1 : 0;
            if (!lvl[b])               blk[b] = 1'b0;
            else if (b >= 2 && clr)    blk[b] = 1'b1;
            h[b] = {h[b][1:0], raw[b]};
        end
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step(btn, minute_tick);
    end

    // ---------------- scoreboard: every cycle ----------------
    always @(negedge clk) begin
        if (n_vec > 0 || !rst_n) begin
            n_vec++;
            if (state !== 4'(m_state) || set_temp !== 12'(m_temp) || set_hum !== 8'(m_hum) ||
                time_hours !== 5'(m_mod / 60) || time_minutes !== 6'(m_mod % 60) ||
                sunrise_hours !== 5'(m_sun_h) || sunrise_minutes !== 6'(m_sun_m)) begin
                n_err++;
                $display("FAIL cycle_cmp t=%0t got st=%0d T=%0d H=%0d %0d:%0d sun %0d:%0d want st=%0d T=%0d H=%0d %0d:%0d sun %0d:%0d",
                         $time, state, set_temp, set_hum, time_hours, time_minutes, sunrise_hours, sunrise_minutes,
                         m_state, m_temp, m_hum, m_mod / 60, m_mod % 60, m_sun_h, m_sun_m);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic press(input int b, input int len);
        @(negedge clk);
        btn[b] = 1'b1;
        repeat (len) @(negedge clk);
        btn[b] = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic press2(input int b0, input int b1, input int len);
        @(negedge clk);
        btn[b0] = 1'b1;
        btn[b1] = 1'b1;
        repeat (len) @(negedge clk);
        btn[b0] = 1'b0;
        btn[b1] = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic pulse_tick();
        @(negedge clk);
        minute_tick = 1'b1;
        @(negedge clk);
        minute_tick = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    // Press b and raise minute_tick so both land on the same edge.
    task automatic step_with_tick(input int b);
        @(negedge clk);
        btn[b] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        minute_tick = 1'b1;
        @(negedge clk);
        minute_tick = 1'b0;
        btn[b] = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        repeat (3) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_temp", set_temp, 75);
        chk("rst_hum", set_hum, 50);
        chk("rst_time", time_hours * 60 + time_minutes, 0);
        chk("rst_sun", sunrise_hours * 60 + sunrise_minutes, 360);
        #2 rst_n = 1'b1;

        // Next pressed one cycle after reset release: moves on the 3rd edge.
        @(negedge clk);
        btn[B_NEXT] = 1'b1;
        @(negedge clk); chk("lat_edge1", state, 0);
        @(negedge clk); chk("lat_edge2", state, 0);
        @(negedge clk); chk("lat_edge3", state, 1);
        repeat (3) @(negedge clk);
        btn[B_NEXT] = 1'b0;
        repeat (5) @(negedge clk);
        chk("next_no_repeat", state, 1);

        // Temperature: auto-repeat from 75 to 119, then saturate at 120.
        press(B_PREV, 2);
        press(B_UP, 180);
        chk("temp_repeat", set_temp, 119);
        for (int i = 0; i < 3; i++) begin
            press(B_UP, 2);
            chk("temp_sat", set_temp, 120);
        end

        // Humidity: down to 0, saturate, then the repeat timing from 0.
        press(B_NEXT, 2);
        press(B_DN, 205);
        chk("hum_down", set_hum, 0);
        press(B_DN, 2);
        chk("hum_floor", set_hum, 0);
        press(B_UP, 30);
        chk("hum_hold30", set_hum, 6);
        repeat (12) @(negedge clk);
        chk("hum_released", set_hum, 6);

        // Clock: set 23:59, tick to 00:00, minute wrap with no carry.
        press(B_NEXT, 2);
        press(B_DN, 2);
        press(B_NEXT, 2);
        press(B_DN, 2);
        chk("time_2359", time_hours * 60 + time_minutes, 23 * 60 + 59);
        pulse_tick();
        chk("tick_wrap", time_hours * 60 + time_minutes, 0);
        press(B_DN, 2);
        press(B_UP, 2);
        chk("min_nocarry", time_hours * 60 + time_minutes, 0);

        // Collisions: tick dropped on TIME_H, kept on TEMP.
        press(B_PREV, 2);
        step_with_tick(B_UP);
        chk("coll_th", time_hours * 60 + time_minutes, 60);
        press(B_PREV, 2);
        press(B_PREV, 2);
        step_with_tick(B_DN);
        chk("coll_temp", set_temp, 119);
        chk("coll_time", time_hours * 60 + time_minutes, 61);

        // Cursor wrap and opposing buttons.
        for (int i = 0; i < 5; i++) press(B_NEXT, 2);
        chk("cur_5", state, 5);
        press(B_NEXT, 2);
        chk("cur_wrap_up", state, 0);
        press(B_PREV, 2);
        chk("cur_wrap_dn", state, 5);
        press2(B_NEXT, B_PREV, 3);
        chk("cur_both", state, 5);
        press2(B_UP, B_DN, 20);
        chk("updn_both", sunrise_hours * 60 + sunrise_minutes, 360);

        // Randomized phase with one reset in the middle.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            for (int b = 0; b < 4; b++) begin
                if (btn[b]) begin
                    if ($urandom_range(0, (b >= 2) ? 23 : 3) == 0) btn[b] = 1'b0;
                end else if ($urandom_range(0, (b >= 2) ? 30 : 40) == 0) begin
                    btn[b] = 1'b1;
                end
            end
            minute_tick = !minute_tick && ($urandom_range(0, 7) == 0);
            if (c == 1500) begin
                #2 rst_n = 1'b0;
                repeat (3) @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end
        btn = 4'b0000;
        minute_tick = 1'b0;
        repeat (10) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound so the run can never hang.
    initial begin
        #2000000;
        $display("FAIL timeout got running want finished");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "timeout");
    end

endmodule
